multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I subset core (R-type, ADDI, LW, SW, BEQ, LUI, JAL, JALR).

---
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the RV32I subset core
module multicycle_ctrl #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             alu_src_imm,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic             retire,
    output logic [RET_W-1:0] retire_cnt
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t     state, state_nx;
    logic [6:0] opcode;
    logic       supported;

    assign opcode    = instr[6:0];
    assign supported = (opcode == OP_R)   || (opcode == OP_ADDI) ||
                       (opcode == OP_LW)  || (opcode == OP_SW)   ||
                       (opcode == OP_BEQ) || (opcode == OP_LUI)  ||
                       (opcode == OP_JAL) || (opcode == OP_JALR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            retire_cnt <= '0;
        end else begin
            state <= state_nx;
            if (retire) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 2'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = 2'd0;
        reg_write   = 1'b0;
        wb_sel      = 2'd0;
        illegal     = 1'b0;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nx = supported ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op   = 2'd2;
                        state_nx = S_WB;
                    end
                    OP_ADDI: begin
                        alu_op      = 2'd2;
                        alu_src_imm = 1'b1;
                        state_nx    = S_WB;
                    end
                    OP_LUI: state_nx = S_WB;
                    OP_LW, OP_SW: begin
                        alu_src_imm = 1'b1;
                        state_nx    = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = 2'd1;
                        pc_write = 1'b1;
                        pc_sel   = alu_zero ? 2'd1 : 2'd0;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    OP_JAL: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                        pc_write  = 1'b1;
                        pc_sel    = 2'd1;
                        retire    = 1'b1;
                        state_nx  = S_FETCH;
                    end
                    OP_JALR: begin
                        alu_src_imm = 1'b1;
                        reg_write   = 1'b1;
                        wb_sel      = 2'd2;
                        pc_write    = 1'b1;
                        pc_sel      = 2'd2;
                        retire      = 1'b1;
                        state_nx    = S_FETCH;
                    end
                    default: state_nx = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LW)  ? 2'd1 :
                            (opcode == OP_LUI) ? 2'd3 : 2'd0;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
        // Outputs drop the moment reset asserts, without waiting for a clock edge.
        if (!rst_n) begin
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_sel      = 2'd0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            alu_src_imm = 1'b0;
            alu_op      = 2'd0;
            reg_write   = 1'b0;
            wb_sel      = 2'd0;
            illegal     = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int RET_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr;
    logic             mem_ready;
    logic             alu_zero;
    logic             ir_write, pc_write, mem_req, mem_we, addr_sel, alu_src_imm;
    logic             reg_write, illegal, retire;
    logic [1:0]       pc_sel, alu_op, wb_sel;
    logic [RET_W-1:0] retire_cnt;

    multicycle_ctrl #(.RET_W(RET_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .ir_write(ir_write), .pc_write(pc_write),
        .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal),
        .retire(retire), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Packed control vector: ir_write,pc_write,pc_sel,mem_req,mem_we,addr_sel,alu_src_imm,alu_op,reg_write,wb_sel,illegal,retire
    logic [14:0] obs;
    assign obs = {ir_write, pc_write, pc_sel, mem_req, mem_we, addr_sel, alu_src_imm,
                  alu_op, reg_write, wb_sel, illegal, retire};

    typedef struct {
        logic        rdy;
        logic        zero;
        logic [14:0] exp;
        string       tag;
    } step_t;

    step_t            sb[$];
    int               errors = 0;
    int               checks = 0;
    logic [RET_W-1:0] exp_cnt = '0;

    function automatic logic [14:0] ex(input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic mreq, input logic mwe, input logic as,
                                       input logic asi, input logic [1:0] aop, input logic rw,
                                       input logic [1:0] wbs, input logic ill, input logic ret);
        return {irw, pcw, pcs, mreq, mwe, as, asi, aop, rw, wbs, ill, ret};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic rdy, input logic zero, input logic [14:0] e);
        step_t s;
        s.rdy  = rdy;
        s.zero = zero;
        s.exp  = e;
        s.tag  = tag;
        sb.push_back(s);
    endtask

    // Inputs are driven just after a rising edge; outputs sampled on the falling edge.
    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            mem_ready = s.rdy;
            alu_zero  = s.zero;
            @(negedge clk);
            check(s.tag, {17'd0, obs}, {17'd0, s.exp});
            check({s.tag, "_cnt"}, {{(32-RET_W){1'b0}}, retire_cnt}, {{(32-RET_W){1'b0}}, exp_cnt});
            @(posedge clk);
            if (s.exp[0]) exp_cnt = exp_cnt + 1'b1;
            #1;
        end
    endtask

    logic [14:0] f_wait, f_go, dec;

    task automatic fetch(input logic [31:0] i, input int waits);
        instr = i;
        for (int k = 0; k < waits; k++) push("fetch_wait", 1'b0, 1'b0, f_wait);
        push("fetch", 1'b1, 1'b0, f_go);
        push("decode", 1'b1, 1'b0, dec);
    endtask

    initial begin
        f_wait = ex(0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0);
        f_go   = ex(1, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0);
        dec    = '0;
        rst_n = 1'b0;
        instr = 32'd0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {17'd0, obs}, 32'd0);
        check("reset_cnt", {{(32-RET_W){1'b0}}, retire_cnt}, 32'd0);
        rst_n = 1'b1;

        // ADDI x1,x0,5
        fetch(32'h00500093, 0);
        push("addi_exec", 1'b0, 1'b0, ex(0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 0, 0));
        push("addi_wb", 1'b0, 1'b0, ex(0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 1));
        drain();

        // LW with three wait cycles in MEM
        fetch(32'h0000A103, 1);
        push("lw_exec", 1'b0, 1'b0, ex(0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 0, 0));
        for (int k = 0; k < 3; k++)
            push("lw_mem_wait", 1'b0, 1'b0, ex(0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 0, 0));
        push("lw_mem_rdy", 1'b1, 1'b0, ex(0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 0, 0));
        push("lw_wb", 1'b1, 1'b0, ex(0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 0, 1));
        drain();

        // SW
        fetch(32'h0020A023, 0);
        push("sw_exec", 1'b0, 1'b0, ex(0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 0, 0));
        push("sw_mem_wait", 1'b0, 1'b0, ex(0, 0, 2'd0, 1, 1, 1, 0, 2'd0, 0, 2'd0, 0, 0));
        push("sw_mem_rdy", 1'b1, 1'b0, ex(0, 1, 2'd0, 1, 1, 1, 0, 2'd0, 0, 2'd0, 0, 1));
        drain();

        // BEQ taken then not taken
        fetch(32'h00208463, 0);
        push("beq_taken", 1'b0, 1'b1, ex(0, 1, 2'd1, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 1));
        fetch(32'h00208463, 0);
        push("beq_not_taken", 1'b0, 1'b0, ex(0, 1, 2'd0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 1));
        drain();

        // JAL then JALR
        fetch(32'h0000006F, 0);
        push("jal_exec", 1'b0, 1'b0, ex(0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 1, 2'd2, 0, 1));
        drain();
        fetch(32'h000080E7, 0);
        push("jalr_exec", 1'b0, 1'b0, ex(0, 1, 2'd2, 0, 0, 0, 1, 2'd0, 1, 2'd2, 0, 1));
        drain();

        // Illegal opcode: trap is sticky and ignores mem_ready
        fetch(32'hFFFFFFFF, 0);
        for (int k = 0; k < 4; k++)
            push("trap", 1'b1, 1'b0, ex(0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0));
        drain();

        rst_n = 1'b0;
        #1;
        check("trap_reset_outs", {17'd0, obs}, 32'd0);
        check("trap_reset_cnt", {{(32-RET_W){1'b0}}, retire_cnt}, 32'd0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset asserted while fetch waits on memory
        push("fetch_wait", 1'b0, 1'b0, f_wait);
        push("fetch_wait", 1'b0, 1'b0, f_wait);
        drain();
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {17'd0, obs}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sixteen retires wrap the 4-bit counter back to zero
        for (int n = 0; n < 16; n++) begin
            fetch(32'h0000006F, 0);
            push("wrap_jal", 1'b0, 1'b0, ex(0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 1, 2'd2, 0, 1));
            drain();
        end
        check("wrap_cnt", {{(32-RET_W){1'b0}}, retire_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
